mc_controller: RTL and testbench

//  Multicycle successor of the single-cycle RV32I control unit: one FSM drives a shared-memory datapath
//  (fetch/decode/execute/writeback) and adds a custom-0 opcode that launches the GCD/LCM coprocessor.

---
 rtl/mc_controller.sv | 186 ++++++++++++++++++
 tb/tb_mc_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM with a custom-0 opcode that hands off to a GCD/LCM coprocessor.
// Control outputs decode from the current state; cop_mode/cop_err are registered.
module mc_controller #(
    parameter logic [6:0]  COP_OPCODE  = 7'b0001011,
    parameter int unsigned TIMEOUT_W   = 8,
    parameter int unsigned COP_TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       cop_done,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       cop_start,
    output logic       cop_mode,
    output logic       cop_err
);

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR,
        StExecI, StAluWb, StBranch, StJal, StCopStart, StCopWait, StCopWb
    } state_t;

    localparam logic [TIMEOUT_W-1:0] LastCount = TIMEOUT_W'(COP_TIMEOUT - 1);

    state_t               state_q;
    logic [TIMEOUT_W-1:0] count_q;
    logic [2:0]           alu_funct;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StFetch;
            count_q  <= '0;
            cop_mode <= 1'b0;
            cop_err  <= 1'b0;
        end else begin
            unique case (state_q)
                StFetch:  state_q <= StDecode;
                StDecode: begin
                    case (op)
                        7'b0000011, 7'b0100011: state_q <= StMemAdr;
                        7'b0110011:             state_q <= StExecR;
                        7'b0010011:             state_q <= StExecI;
                        7'b1100011:             state_q <= StBranch;
                        7'b1101111:             state_q <= StJal;
                        COP_OPCODE:             state_q <= StCopStart;
                        default:                state_q <= StFetch;
                    endcase
                end
                StMemAdr:   state_q <= op[5] ? StMemWrite : StMemRead;
                StMemRead:  state_q <= StMemWb;
                StMemWb:    state_q <= StFetch;
                StMemWrite: state_q <= StFetch;
                StExecR:    state_q <= StAluWb;
                StExecI:    state_q <= StAluWb;
                StAluWb:    state_q <= StFetch;
                StBranch:   state_q <= StFetch;
                StJal:      state_q <= StAluWb;
                StCopStart: begin
                    cop_mode <= funct3[0];
                    count_q  <= '0;
                    state_q  <= StCopWait;
                end
                StCopWait: begin
                    // A done pulse landing on the final wait cycle still counts as success.
                    if (cop_done) begin
                        state_q <= StCopWb;
                    end else if (count_q == LastCount) begin
                        cop_err <= 1'b1;
                        state_q <= StFetch;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                StCopWb:  state_q <= StFetch;
                default:  state_q <= StFetch;
            endcase
        end
    end

    always_comb begin
        unique case (funct3)
            3'b000:  alu_funct = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
            3'b010:  alu_funct = 3'b101;
            3'b110:  alu_funct = 3'b011;
            3'b111:  alu_funct = 3'b010;
            default: alu_funct = 3'b000;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        RegWrite   = 1'b0;
        cop_start  = 1'b0;
        case (op)
            7'b0100011: ImmSrc = 2'b01;
            7'b1100011: ImmSrc = 2'b10;
            7'b1101111: ImmSrc = 2'b11;
            default:    ImmSrc = 2'b00;
        endcase
        unique case (state_q)
            StFetch: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ResultSrc = 2'b10;
                ALUSrcB   = 2'b10;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            StMemRead: AdrSrc = 1'b1;
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            StMemWrite: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            StExecR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_funct;
            end
            StExecI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_funct;
            end
            StAluWb: RegWrite = 1'b1;
            StBranch: begin
                ALUSrcA    = 2'b10;
                ALUControl = 3'b001;
                PCWrite    = Zero ^ funct3[0];
            end
            StJal: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            StCopStart: cop_start = 1'b1;
            StCopWb: begin
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
            end
            default: ;
        endcase
        // Reset state is FETCH, but nothing may be enabled while reset is held.
        if (!reset_n) begin
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ImmSrc     = 2'b00;
            ALUControl = 3'b000;
            RegWrite   = 1'b0;
            cop_start  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: instruction-level reference model, directed table, reset and
// coprocessor-timeout sequences, then randomized instruction streams.
module tb_mc_controller;

    localparam logic [6:0] COP = 7'b0001011;
    localparam int         TMO = 200;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       cop_done = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, cop_start, cop_mode, cop_err;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    always #5 clk = ~clk;

    mc_controller #(.COP_OPCODE(COP), .TIMEOUT_W(8), .COP_TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .cop_done(cop_done), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .RegWrite(RegWrite),
        .cop_start(cop_start), .cop_mode(cop_mode), .cop_err(cop_err)
    );

    typedef struct packed {
        logic pcw, adr, mw, irw;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
        logic rw, cs;
    } ctl_t;

    typedef struct {
        ctl_t ctl;
        logic done;
        logic m, e;
    } step_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic f7, z;
        int dlat, cyc, rw, mw, pcw;
        logic [2:0] alu3;
    } vec_t;

    ctl_t  act;
    step_t q[$];
    logic  exp_mode = 1'b0, exp_err = 1'b0;
    int    checks = 0, errors = 0;

    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
                  ALUControl, RegWrite, cop_start};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7);
        case (f3)
            3'b000:  return (f7 && o[5]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic void push(input ctl_t c, input logic d);
        step_t s;
        s.ctl = c;
        s.done = d;
        s.m = exp_mode;
        s.e = exp_err;
        q.push_back(s);
    endfunction

    // Expected per-cycle control words for one instruction, from the instruction's phase list.
    function automatic void build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                  input logic z, input int dlat);
        ctl_t base, c;
        base = '0;
        base.imm = imm_of(o);
        c = base; c.pcw = 1; c.irw = 1; c.rs = 2'b10; c.sb = 2'b10;
        push(c, 1'($urandom_range(0, 1)));
        c = base; c.sa = 2'b01; c.sb = 2'b01;
        push(c, 1'($urandom_range(0, 1)));
        case (o)
            7'b0000011, 7'b0100011: begin
                c = base; c.sa = 2'b10; c.sb = 2'b01;
                push(c, 1'($urandom_range(0, 1)));
                if (o == 7'b0000011) begin
                    c = base; c.adr = 1;
                    push(c, 1'($urandom_range(0, 1)));
                    c = base; c.rs = 2'b01; c.rw = 1;
                    push(c, 1'($urandom_range(0, 1)));
                end else begin
                    c = base; c.adr = 1; c.mw = 1;
                    push(c, 1'($urandom_range(0, 1)));
                end
            end
            7'b0110011, 7'b0010011: begin
                c = base; c.sa = 2'b10; c.sb = o[5] ? 2'b00 : 2'b01; c.alu = alu_of(o, f3, f7);
                push(c, 1'($urandom_range(0, 1)));
                c = base; c.rw = 1;
                push(c, 1'($urandom_range(0, 1)));
            end
            7'b1100011: begin
                c = base; c.sa = 2'b10; c.alu = 3'b001; c.pcw = z ^ f3[0];
                push(c, 1'($urandom_range(0, 1)));
            end
            7'b1101111: begin
                c = base; c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1;
                push(c, 1'($urandom_range(0, 1)));
                c = base; c.rw = 1;
                push(c, 1'($urandom_range(0, 1)));
            end
            COP: begin
                c = base; c.cs = 1;
                push(c, 1'($urandom_range(0, 1)));
                exp_mode = f3[0];
                for (int j = 0; j < TMO; j++) begin
                    push(base, j == dlat);
                    if (j == dlat) break;
                end
                if (dlat < TMO) begin
                    c = base; c.rs = 2'b11; c.rw = 1;
                    push(c, 1'($urandom_range(0, 1)));
                end else begin
                    exp_err = 1'b1;
                end
            end
            default: ;
        endcase
    endfunction

    // Runs one instruction starting in FETCH (called just after a rising edge). stop >= 0 aborts
    // after that many cycles, leaving the DUT mid-instruction.
    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                       input int dlat, input int stop, output int len, output int rw,
                       output int mw, output int pcw, output logic [2:0] alu3);
        q.delete();
        build(o, f3, f7, z, dlat);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        len = -1; rw = 0; mw = 0; pcw = 0; alu3 = 3'b000;
        for (int k = 0; k < q.size(); k++) begin
            if (stop >= 0 && k == stop) return;
            cop_done = q[k].done;
            @(negedge clk);
            check("ctl", 32'(act), 32'(q[k].ctl));
            check("mode_err", {30'd0, cop_mode, cop_err}, {30'd0, q[k].m, q[k].e});
            if (k > 0 && IRWrite && len < 0) len = k;
            if (k == 2) alu3 = ALUControl;
            rw += int'(RegWrite);
            mw += int'(MemWrite);
            pcw += int'(PCWrite);
            @(posedge clk);
            #1;
        end
        cop_done = 1'b0;
        if (len < 0 && IRWrite) len = q.size();
    endtask

    // Pulses reset mid-cycle, checks outputs are forced low, releases just after an edge.
    task automatic do_reset();
        ctl_t f;
        #1 reset_n = 1'b0;
        cop_done = 1'b0;
        #1;
        check("rst_ctl", 32'(act), 32'd0);
        check("rst_mode_err", {30'd0, cop_mode, cop_err}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        f = '0; f.pcw = 1; f.irw = 1; f.rs = 2'b10; f.sb = 2'b10; f.imm = imm_of(op);
        check("post_rst_fetch", 32'(act), 32'(f));
        exp_mode = 1'b0;
        exp_err = 1'b0;
    endtask

    vec_t tbl[16];
    logic [6:0] rops[8];

    initial begin
        int len, rw, mw, pcw;
        logic [2:0] alu3;
        tbl[0]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 0, 4, 1, 0, 1, 3'b000};   // add
        tbl[1]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 0, 4, 1, 0, 1, 3'b001};   // sub
        tbl[2]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 0, 4, 1, 0, 1, 3'b000};   // addi, f7b5 ignored
        tbl[3]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 0, 4, 1, 0, 1, 3'b101};   // slt
        tbl[4]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 0, 4, 1, 0, 1, 3'b011};   // or
        tbl[5]  = '{7'b0010011, 3'b111, 1'b0, 1'b0, 0, 4, 1, 0, 1, 3'b010};   // andi
        tbl[6]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 0, 5, 1, 0, 1, 3'b000};   // lw
        tbl[7]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 0, 4, 0, 1, 1, 3'b000};   // sw
        tbl[8]  = '{7'b1100011, 3'b000, 1'b0, 1'b1, 0, 3, 0, 0, 2, 3'b001};   // beq taken
        tbl[9]  = '{7'b1100011, 3'b001, 1'b0, 1'b1, 0, 3, 0, 0, 1, 3'b001};   // bne not taken
        tbl[10] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 0, 4, 1, 0, 2, 3'b000};   // jal
        tbl[11] = '{7'b0110111, 3'b000, 1'b0, 1'b0, 0, 2, 0, 0, 1, 3'b000};   // unsupported -> nop
        tbl[12] = '{COP,        3'b001, 1'b0, 1'b0, 6, 11, 1, 0, 1, 3'b000};  // lcm, 7 wait cycles
        tbl[13] = '{COP,        3'b000, 1'b0, 1'b0, 199, 204, 1, 0, 1, 3'b000}; // done on last cycle
        tbl[14] = '{COP,        3'b000, 1'b0, 1'b0, 1000, 203, 0, 0, 1, 3'b000}; // timeout
        tbl[15] = '{7'b1100011, 3'b001, 1'b0, 1'b0, 0, 3, 0, 0, 2, 3'b001};   // bne taken
        rops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                 COP, 7'b0110111};

        @(posedge clk);
        do_reset();

        // Reset while the add is in EXECR.
        run(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 2, len, rw, mw, pcw, alu3);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            run(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].dlat, -1, len, rw, mw, pcw,
                alu3);
            check($sformatf("len[%0d]", i), 32'(len), 32'(tbl[i].cyc));
            check($sformatf("regwrite[%0d]", i), 32'(rw), 32'(tbl[i].rw));
            check($sformatf("memwrite[%0d]", i), 32'(mw), 32'(tbl[i].mw));
            check($sformatf("pcwrite[%0d]", i), 32'(pcw), 32'(tbl[i].pcw));
            if (tbl[i].cyc > 2) check($sformatf("alu3[%0d]", i), 32'(alu3), 32'(tbl[i].alu3));
        end
        check("err_sticky", 32'(cop_err), 32'd1);

        do_reset();
        // Reset in the middle of a coprocessor wait must leave cop_err clear.
        run(COP, 3'b001, 1'b0, 1'b0, 1000, 40, len, rw, mw, pcw, alu3);
        do_reset();
        check("abort_no_err", 32'(cop_err), 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [6:0] o;
            int dl;
            o = rops[$urandom_range(0, 7)];
            dl = ($urandom_range(0, 39) == 0) ? 250 : int'($urandom_range(0, 30));
            run(o, 3'($urandom), 1'($urandom), 1'($urandom), dl, -1, len, rw, mw, pcw, alu3);
            check("rand_len", 32'(len), 32'(q.size()));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
